// File: rtl/packetizer_pkg.sv
// -----------------------------------------------------------------------------
// packetizer_pkg
// Shared types and elaboration-time helpers for the destination-append
// serialising packetizer.
//   - state_t            : FSM state encoding (idle / sending flits)
//   - *_OFS / CTRL_BITS  : position of the valid/head/tail bits counted from
//                          the flit MSB (VALID_POS = WIDTH_OUT - VALID_OFS ...)
//   - head_payload_width : payload bits that fit in the head flit
//   - body_payload_width : payload bits that fit in each body flit
//   - flit_count         : flits needed for a payload of a given width
//   - cnt_width          : width of a counter indexing those flits
// -----------------------------------------------------------------------------
package packetizer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Control bits sit at the top of every flit: {valid, head, tail, ...}
    localparam int CTRL_BITS = 3;
    localparam int VALID_OFS = 1;
    localparam int HEAD_OFS  = 2;
    localparam int TAIL_OFS  = 3;

    function automatic int head_payload_width(input int width_out,
                                              input int address_width,
                                              input int vc_address_width);
        return width_out - CTRL_BITS - vc_address_width - address_width;
    endfunction

    function automatic int body_payload_width(input int width_out,
                                              input int vc_address_width);
        return width_out - CTRL_BITS - vc_address_width;
    endfunction

    // One head flit plus enough body flits for whatever did not fit in it.
    // A non-positive head width is caught separately by the top module, so
    // just return something harmless here to keep elaboration going.
    function automatic int flit_count(input int pw,
                                      input int width_out,
                                      input int address_width,
                                      input int vc_address_width);
        int hpw;
        int bpw;
        int rem;
        hpw = head_payload_width(width_out, address_width, vc_address_width);
        bpw = body_payload_width(width_out, vc_address_width);
        if (hpw < 1) begin
            return 1;
        end
        rem = pw - hpw;
        if (rem <= 0) begin
            return 1;
        end
        return 1 + (rem + bpw - 1) / bpw;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/packetizer_da_serial_if.sv
// -----------------------------------------------------------------------------
// packetizer_da_serial_if
// Bundles the upstream word handshake and the downstream flit handshake of the
// packetizer.
//   data_in/dst_in/vc_in/valid_in : user word, destination and VC (to packetizer)
//   ready_out                     : word accepted when valid_in && ready_out
//   data_out/valid_out            : NoC flit stream (from packetizer)
//   ready_in                      : flit accepted when valid_out && ready_in
// Modports:
//   master : the packetizer itself
//   slave  : the surrounding logic (producer + NoC port)
// -----------------------------------------------------------------------------
interface packetizer_da_serial_if #(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int WIDTH_IN         = 64,
    parameter int WIDTH_OUT        = 36
);
    logic [WIDTH_IN-1:0]         data_in;
    logic                        valid_in;
    logic [ADDRESS_WIDTH-1:0]    dst_in;
    logic [VC_ADDRESS_WIDTH-1:0] vc_in;
    logic                        ready_out;
    logic [WIDTH_OUT-1:0]        data_out;
    logic                        valid_out;
    logic                        ready_in;

    modport master (
        input  data_in,
        input  valid_in,
        input  dst_in,
        input  vc_in,
        output ready_out,
        output data_out,
        output valid_out,
        input  ready_in
    );

    modport slave (
        output data_in,
        output valid_in,
        output dst_in,
        output vc_in,
        input  ready_out,
        input  data_out,
        input  valid_out,
        output ready_in
    );
endinterface

// File: rtl/flit_slicer.sv
// -----------------------------------------------------------------------------
// flit_slicer
// Combinational flit formatter. Builds every flit of the packet from the held
// payload and selects the one addressed by flit_cnt.
//   valid    : flit is being presented; also drives the flit's valid bit.
//              When low the whole flit is forced to zero.
//   payload  : {RET_DEST, RET_VC, data} as captured on accept
//   dst, vc  : captured destination and VC
//   flit_cnt : index of the flit to present (0 = head)
//   flit     : {valid, head, tail, vc, [dst on head], chunk}
// -----------------------------------------------------------------------------
module flit_slicer
    import packetizer_pkg::*;
#(
    parameter int ADDRESS_WIDTH    = 4,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int PW               = 69,
    parameter int WIDTH_OUT        = 36,
    parameter int NUM_FLITS        = 3,
    parameter int CNT_W            = 2
) (
    input  logic                        valid,
    input  logic [PW-1:0]               payload,
    input  logic [ADDRESS_WIDTH-1:0]    dst,
    input  logic [VC_ADDRESS_WIDTH-1:0] vc,
    input  logic [CNT_W-1:0]            flit_cnt,
    output logic [WIDTH_OUT-1:0]        flit
);

    localparam int HPW       = head_payload_width(WIDTH_OUT, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
    localparam int BPW       = body_payload_width(WIDTH_OUT, VC_ADDRESS_WIDTH);
    localparam int VALID_POS = WIDTH_OUT - VALID_OFS;
    localparam int HEAD_POS  = WIDTH_OUT - HEAD_OFS;
    localparam int TAIL_POS  = WIDTH_OUT - TAIL_OFS;
    // Payload zero-extended to exactly fill all flit chunks; this is what
    // leaves the unused MSBs of the last flit at zero.
    localparam int PADW      = HPW + (NUM_FLITS - 1) * BPW;

    logic [PADW-1:0]      pad;
    logic [WIDTH_OUT-1:0] flits [NUM_FLITS];
    logic [WIDTH_OUT-1:0] sel;

    assign pad = PADW'(payload);

    // Head flit: carries the destination and the lowest HPW payload bits.
    assign flits[0] = {1'b1, 1'b1, (NUM_FLITS == 1) ? 1'b1 : 1'b0,
                       vc, dst, pad[HPW-1:0]};

    // Body flits: successive BPW-bit slices, LSB-first after the head chunk.
    generate
        for (genvar gi = 1; gi < NUM_FLITS; gi++) begin : g_body
            assign flits[gi] = {1'b1, 1'b0, (gi == NUM_FLITS - 1) ? 1'b1 : 1'b0,
                                vc, pad[HPW + (gi - 1) * BPW +: BPW]};
        end
    endgenerate

    always_comb begin
        sel = '0;
        for (int k = 0; k < NUM_FLITS; k++) begin
            if (int'(flit_cnt) == k) begin
                sel = flits[k];
            end
        end
    end

    always_comb begin
        flit = '0;
        if (valid) begin
            flit            = sel;
            flit[VALID_POS] = 1'b1;
            flit[HEAD_POS]  = sel[HEAD_POS];
            flit[TAIL_POS]  = sel[TAIL_POS];
        end
    end

endmodule

// File: rtl/packetizer_da_serial.sv
// -----------------------------------------------------------------------------
// packetizer_da_serial
// Accepts one user word with destination and VC, appends the local return
// address {RET_DEST, RET_VC} above the data, and serialises the result into
// NUM_FLITS NoC flits (head, bodies, tail). Back-to-back packets are accepted
// in the cycle the previous tail is taken, so a steady stream runs without
// bubbles.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset; also forces outputs low while high
//   bus  : packetizer_da_serial_if.master (word in, flit out, both ready/valid)
// ready_out has a combinational path from ready_in (accept on last flit).
// -----------------------------------------------------------------------------
module packetizer_da_serial
    import packetizer_pkg::*;
#(
    parameter int                          ADDRESS_WIDTH    = 4,
    parameter int                          VC_ADDRESS_WIDTH = 1,
    parameter int                          WIDTH_IN         = 64,
    parameter int                          WIDTH_OUT        = 36,
    parameter logic [ADDRESS_WIDTH-1:0]    RET_DEST         = '0,
    parameter logic [VC_ADDRESS_WIDTH-1:0] RET_VC           = '0,
    parameter int                          MAX_FLITS        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    packetizer_da_serial_if.master bus
);

    localparam int PW        = WIDTH_IN + ADDRESS_WIDTH + VC_ADDRESS_WIDTH;
    localparam int HPW       = head_payload_width(WIDTH_OUT, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
    localparam int NUM_FLITS = flit_count(PW, WIDTH_OUT, ADDRESS_WIDTH, VC_ADDRESS_WIDTH);
    localparam int CNT_W     = cnt_width(NUM_FLITS);

    generate
        if (HPW < 1) begin : g_chk_hpw
            $fatal(1, "packetizer_da_serial: WIDTH_OUT too small, head payload width %0d", HPW);
        end
        if (NUM_FLITS > MAX_FLITS) begin : g_chk_flits
            $fatal(1, "packetizer_da_serial: %0d flits needed, MAX_FLITS is %0d",
                   NUM_FLITS, MAX_FLITS);
        end
    endgenerate

    state_t                      state_reg, state_next;
    logic [CNT_W-1:0]            flit_cnt_reg, flit_cnt_next;
    logic [PW-1:0]               payload_reg, payload_next;
    logic [ADDRESS_WIDTH-1:0]    dst_reg, dst_next;
    logic [VC_ADDRESS_WIDTH-1:0] vc_reg, vc_next;

    logic last_flit;
    logic capture;
    logic ready_int;
    logic valid_int;
    logic valid_gated;

    assign last_flit = (flit_cnt_reg == CNT_W'(NUM_FLITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            flit_cnt_reg <= '0;
            payload_reg  <= '0;
            dst_reg      <= '0;
            vc_reg       <= '0;
        end else begin
            state_reg    <= state_next;
            flit_cnt_reg <= flit_cnt_next;
            payload_reg  <= payload_next;
            dst_reg      <= dst_next;
            vc_reg       <= vc_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        flit_cnt_next = flit_cnt_reg;
        payload_next  = payload_reg;
        dst_next      = dst_reg;
        vc_next       = vc_reg;
        ready_int     = 1'b0;
        valid_int     = 1'b0;
        capture       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                ready_int = 1'b1;
                if (bus.valid_in) begin
                    capture    = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                valid_int = 1'b1;
                if (bus.ready_in) begin
                    if (!last_flit) begin
                        flit_cnt_next = flit_cnt_reg + CNT_W'(1);
                    end else begin
                        // Tail taken: the slot is free this very cycle, so a
                        // waiting word can start the next packet with no gap.
                        ready_int = 1'b1;
                        if (bus.valid_in) begin
                            capture = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
            end
        endcase

        if (capture) begin
            payload_next  = {RET_DEST, RET_VC, bus.data_in};
            dst_next      = bus.dst_in;
            vc_next       = bus.vc_in;
            flit_cnt_next = '0;
        end
    end

    // Outputs are held low for the whole time rst is high, not just after
    // the reset edge, so an interrupted packet disappears immediately.
    assign valid_gated   = valid_int & ~rst;
    assign bus.valid_out = valid_gated;
    assign bus.ready_out = ready_int & ~rst;

    flit_slicer #(
        .ADDRESS_WIDTH   (ADDRESS_WIDTH),
        .VC_ADDRESS_WIDTH(VC_ADDRESS_WIDTH),
        .PW              (PW),
        .WIDTH_OUT       (WIDTH_OUT),
        .NUM_FLITS       (NUM_FLITS),
        .CNT_W           (CNT_W)
    ) u_slicer (
        .valid   (valid_gated),
        .payload (payload_reg),
        .dst     (dst_reg),
        .vc      (vc_reg),
        .flit_cnt(flit_cnt_reg),
        .flit    (bus.data_out)
    );

endmodule

// File: doc/packetizer_da_serial.md
Name: packetizer_da_serial

Overview:
Parametrised successor to the fixed-width destination-append packetizers. It accepts one data word plus destination and VC, prepends the local return address (RET_DEST/RET_VC), and serialises the result into as many NoC flits as WIDTH_OUT requires. The flit count is computed at elaboration rather than chosen from a fixed 1-4 menu. It sits between a module's streaming output and a NoC fabric port, with ready/valid on both sides and back-to-back packet support.

Parameters:
ADDRESS_WIDTH, 4, router address width (dst and return dest)
VC_ADDRESS_WIDTH, 1, virtual-channel id width
WIDTH_IN, 64, user data width
WIDTH_OUT, 36, flit width
RET_DEST, 0, return address appended to payload (ADDRESS_WIDTH bits)
RET_VC, 0, return VC appended to payload (VC_ADDRESS_WIDTH bits)
MAX_FLITS, 8, upper bound on flits per packet; exceeding it is an elaboration error

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
data_in  input  WIDTH_IN  user data
valid_in  input  1  input word valid
dst_in  input  ADDRESS_WIDTH  destination router
vc_in  input  VC_ADDRESS_WIDTH  VC used for all flits of the packet
ready_out  output  1  word accepted when valid_in && ready_out
data_out  output  WIDTH_OUT  flit
valid_out  output  1  flit valid
ready_in  input  1  downstream accepts flit when valid_out && ready_in

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Payload P = {RET_DEST, RET_VC, data_in}. PW = WIDTH_IN + ADDRESS_WIDTH + VC_ADDRESS_WIDTH.
- Head payload width HPW = WIDTH_OUT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH. Body payload width BPW = WIDTH_OUT - 3 - VC_ADDRESS_WIDTH.
- NUM_FLITS = 1 + ceil(max(0, PW - HPW) / BPW).
- Elaboration checks ($fatal): HPW < 1, or NUM_FLITS > MAX_FLITS.
- Flit layout, MSB first: {valid, head, tail, vc, [dst if head], chunk}.
  - Head flit carries P[HPW-1:0].
  - Body flit k (k ≥ 1) carries the next BPW bits of P, taken LSB-first.
  - The last flit's unused MSBs are zero.
  - head = 1 only on flit 0; tail = 1 only on flit NUM_FLITS-1.
  - Bit valid = valid_out.
- FSM states:
  - IDLE: ready_out = 1, valid_out = 0. On accept, capture P/dst/vc into a holding register, set flit_cnt = 0, go to SEND.
  - SEND: valid_out = 1, data_out = flit[flit_cnt]. On ready_in:
    - If flit_cnt < NUM_FLITS-1: flit_cnt++.
    - Otherwise the last flit is accepted. If valid_in is also high, capture the new word, set flit_cnt = 0, stay in SEND. Otherwise go to IDLE.
- ready_out = (state == IDLE) || (state == SEND && last flit && ready_in). This is a combinational path from ready_in and is permitted.
- Latency: word accepted in cycle t → head flit on data_out in cycle t+1.
- Throughput: one packet per NUM_FLITS cycles when ready_in is held high, with no bubbles.
- Backpressure: while valid_out && !ready_in, data_out and valid_out stay stable; the holding register is unchanged.
- Inputs are sampled only on accept; changing dst_in/vc_in/data_in mid-packet has no effect.
- Reset values: valid_out = 0, data_out = 0, ready_out = 0 while rst is high; state IDLE, flit_cnt = 0. ready_out = 1 in the first cycle after rst deasserts.
- Reset mid-packet: the packet is abandoned with no tail emitted. Downstream resets with the same rst.
- NUM_FLITS == 1: head = tail = 1 on every flit; back-to-back acceptance every cycle.

Decomposition:
- Shared package packetizer_pkg: functions flit_count(PW, WIDTH_OUT, ADDRESS_WIDTH, VC_ADDRESS_WIDTH), head_payload_width(...), body_payload_width(...); localparams for flit control-bit positions (VALID_POS = WIDTH_OUT-1, HEAD_POS = WIDTH_OUT-2, TAIL_POS = WIDTH_OUT-3).
- One sub-module, flit_slicer: combinational. Given the held payload, dst, vc and flit_cnt, it produces the formatted flit, including zero padding.
- The FSM, counter and holding register stay in the top module.

Test Plan:
1. Defaults (HPW = 28, BPW = 32, NUM_FLITS = 3), RET_DEST = 4'h3, RET_VC = 0. Stimulus: data_in = 64'h0123_4567_89AB_CDEF, dst_in = 4'h5, vc_in = 1, ready_in = 1. Required: three consecutive flits.
   - Flit 0: {1,1,0,1,4'h5,28'h9AB_CDEF}.
   - Flit 1: {1,0,0,1,32'h1234_5678}.
   - Flit 2: {1,0,1,1,23'h0,9'h060}.
2. Same packet, ready_in = 0 for 4 cycles while flit 1 is presented. Required: flit 1 held bit-exact with valid_out = 1; flit 2 appears only after ready_in returns; ready_out = 0 throughout.
3. Two words with valid_in held, ready_in = 1. Required: 6 flits in 6 consecutive cycles; ready_out pulses during the cycle of each tail; the second head flit immediately follows the first tail.
4. rst asserted for 1 cycle while flit 1 is valid. Required: next cycle valid_out = 0, data_out = 0; ready_out = 1 the cycle after; the next packet starts with a head flit.
5. WIDTH_IN = 16, WIDTH_OUT = 36 (PW = 21 ≤ 28, NUM_FLITS = 1). Stimulus: valid_in every cycle with data 16'hA5A5, 16'h5A5A. Required: one flit per cycle with head = tail = 1, chunk = {7'h0, RET_DEST, RET_VC, data}.
6. Set WIDTH_IN = 300, MAX_FLITS = 8 (NUM_FLITS = 10). Required: elaboration $fatal.
